// File: rtl/fpcvt_rr_scheduler_pkg.sv
// fpcvt_rr_scheduler_pkg: shared widths and scheduler state encoding
package fpcvt_rr_scheduler_pkg;
  localparam int D_W = 13;
  localparam int E_W = 3;
  localparam int F_W = 5;
  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_RESP} state_e;
endpackage

// File: rtl/fpcvt.sv
// fpcvt: 13-bit two's-complement to sign / 3-bit exponent / 5-bit significand, round half up
module fpcvt
  import fpcvt_rr_scheduler_pkg::*;
(
  input  logic [D_W-1:0] d_i,
  output logic           s_o,
  output logic [E_W-1:0] e_o,
  output logic [F_W-1:0] f_o
);
  logic [D_W-1:0] mag;
  logic [3:0] len;
  logic [2:0] sh;
  logic rb, sat;
  logic [5:0] fr;
  always_comb begin
    s_o = d_i[D_W-1];
    mag = d_i[D_W-1] ? -d_i : d_i;
    len = '0;
    for (int i = 0; i < 12; i++) if (mag[i]) len = 4'(i + 1);
    sh = len > 4'd5 ? 3'(len - 4'd5) : 3'd0;
    rb = (sh != 3'd0) & mag[3'(sh - 3'd1)];
    fr = {1'b0, 5'(mag >> sh)} + {5'd0, rb};
    // magnitude 4096 (from -4096) and rounding past E=7 both saturate
    sat = mag[D_W-1] | (fr[5] & (sh == 3'd7));
    e_o = sat ? 3'b111 : sh + {2'b0, fr[5]};
    f_o = sat ? 5'b11111 : fr[5] ? 5'b10000 : fr[4:0];
  end
endmodule

// File: rtl/fpcvt_rr_scheduler_arb.sv
// rr_arbiter: combinational round-robin pick, searching from ptr upward with wrap
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);
  logic found;
  int j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!found && req_i[j]) begin
        found = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/fpcvt_rr_scheduler.sv
// fpcvt_rr_scheduler: round-robin sharing of one FPCVT with registered operand and tagged result
module fpcvt_rr_scheduler
  import fpcvt_rr_scheduler_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int CONV_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*D_W-1:0]  req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [IDW-1:0]       resp_id_o,
  output logic                 resp_s_o,
  output logic [E_W-1:0]       resp_e_o,
  output logic [F_W-1:0]       resp_f_o,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     conv_count_o
);
  localparam int CW = $clog2(CONV_LAT + 1);
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, rid_q, rid_d, gidx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [D_W-1:0] op_q, op_d;
  logic rv_q, rv_d, s_q, s_d, cs;
  logic [E_W-1:0] e_q, e_d, ce;
  logic [F_W-1:0] f_q, f_d, cf;
  logic [CNT_W-1:0] cc_q, cc_d;
  logic [NREQ-1:0] gnt;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (.req_i(req_valid_i), .ptr_i(ptr_q), .gnt_o(gnt), .idx_o(gidx));
  // the converter only ever sees the registered operand
  fpcvt u_fpcvt (.d_i(op_q), .s_o(cs), .e_o(ce), .f_o(cf));
  assign req_ready_o  = (state_q == ST_IDLE && rst_n_i) ? gnt : '0;
  assign busy_o       = state_q != ST_IDLE;
  assign resp_valid_o = rv_q;
  assign resp_id_o    = rid_q;
  assign resp_s_o     = s_q;
  assign resp_e_o     = e_q;
  assign resp_f_o     = f_q;
  assign conv_count_o = cc_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    op_d = op_q;
    id_d = id_q;
    rv_d = rv_q;
    rid_d = rid_q;
    s_d = s_q;
    e_d = e_q;
    f_d = f_q;
    cc_d = cc_q;
    unique case (state_q)
      ST_IDLE: if (|(req_valid_i & req_ready_o)) begin
        op_d = req_data_i[D_W*gidx +: D_W];
        id_d = gidx;
        ptr_d = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        cnt_d = CW'(CONV_LAT - 1);
        state_d = ST_CONV;
      end
      ST_CONV: if (cnt_q == '0) begin
        rid_d = id_q;
        s_d = cs;
        e_d = ce;
        f_d = cf;
        rv_d = 1'b1;
        state_d = ST_RESP;
      end else cnt_d = cnt_q - 1'b1;
      ST_RESP: if (resp_ready_i) begin
        rv_d = 1'b0;
        cc_d = cc_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
      id_q <= '0;
      rv_q <= 1'b0;
      rid_q <= '0;
      s_q <= 1'b0;
      e_q <= '0;
      f_q <= '0;
      cc_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      id_q <= id_d;
      rv_q <= rv_d;
      rid_q <= rid_d;
      s_q <= s_d;
      e_q <= e_d;
      f_q <= f_d;
      cc_q <= cc_d;
    end
  end
endmodule

// File: tb/tb_fpcvt_rr_scheduler.sv
// tb_fpcvt_rr_scheduler: scoreboard bench with arithmetic conversion and arbitration model
module tb_fpcvt_rr_scheduler;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int CNTW = 4;
  logic clk = 0, rst_n = 0, resp_ready = 0;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*13-1:0] req_data = '0;
  logic resp_valid, resp_s, busy;
  logic [1:0] resp_id;
  logic [2:0] resp_e;
  logic [4:0] resp_f;
  logic [CNTW-1:0] conv_count;
  typedef struct {int id; logic [8:0] r; int c;} exp_t;
  exp_t q[$];
  int nchk = 0, npass = 0, cyc = 0, m_ptr = 0, m_count = 0;
  bit prev_v = 0;
  fpcvt_rr_scheduler #(.NREQ(NREQ), .IDW(2), .CONV_LAT(LAT), .CNT_W(CNTW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_id_o(resp_id), .resp_s_o(resp_s), .resp_e_o(resp_e), .resp_f_o(resp_f),
    .busy_o(busy), .conv_count_o(conv_count));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
  endtask
  // value = F * 2^E with the smallest E that fits F in 5 bits, half-up rounding, saturating
  function automatic logic [8:0] model(input logic [12:0] d);
    int v, m, e, f;
    v = int'($signed(d));
    m = v < 0 ? -v : v;
    e = 0;
    while (e < 7 && (m >> e) >= 32) e++;
    f = (m + (e > 0 ? (1 << (e - 1)) : 0)) >> e;
    if (f == 32) begin f = 16; e++; end
    if (e > 7) begin e = 7; f = 31; end
    return {v < 0, 3'(e), 5'(f)};
  endfunction
  task automatic step(input logic [NREQ-1:0] v, input logic rr);
    int g;
    bit any;
    logic [12:0] d;
    req_valid = v;
    resp_ready = rr;
    #1;
    g = 0;
    any = 0;
    if (rst_n && q.size() == 0)
      for (int k = 0; k < NREQ; k++)
        if (!any && v[(m_ptr + k) % NREQ]) begin any = 1; g = (m_ptr + k) % NREQ; end
    chk("req_ready", int'(req_ready), any ? (1 << g) : 0);
    if (rst_n) chk("busy", int'(busy), int'(q.size() != 0));
    if (any) begin
      d = req_data[13*g +: 13];
      q.push_back('{g, model(d), cyc + 1 + LAT});
      m_ptr = (g + 1) % NREQ;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    q.delete();
    m_ptr = 0;
    m_count = 0;
    step('1, 1);
    step('1, 1);
    rst_n = 1;
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_conv_count", int'(conv_count), 0);
  endtask
  task automatic drain();
    for (int i = 0; i < 80 && q.size() != 0; i++) step('0, 1);
    chk("drain_timeout", q.size(), 0);
  endtask
  task automatic set_d(input int i, input int val);
    req_data[13*i +: 13] = 13'(val);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      chk("conv_count", int'(conv_count), m_count);
      if (resp_valid) begin
        if (q.size() == 0) chk("spurious_resp", 1, 0);
        else begin
          chk("resp_id", int'(resp_id), q[0].id);
          chk("resp_sef", int'({resp_s, resp_e, resp_f}), int'(q[0].r));
          if (!prev_v) chk("latency_cycle", cyc, q[0].c);
          if (resp_ready) begin
            void'(q.pop_front());
            m_count = (m_count + 1) % (1 << CNTW);
          end
        end
      end
      prev_v = resp_valid;
    end else prev_v = 0;
  end
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    set_d(0, 108);
    step(4'b0001, 1);
    drain();
    do_reset();
    set_d(0, 0); set_d(1, 110); set_d(2, -422); set_d(3, 4095);
    repeat (4 * (LAT + 2) + 2) step(4'b1111, 1);
    drain();
    do_reset();
    step(4'b0100, 1);
    drain();
    repeat (2 * (LAT + 2) + 2) step(4'b1001, 1);
    drain();
    set_d(0, 2730);
    step(4'b0001, 0);
    repeat (LAT + 10) step(4'b0001, 0);
    step(4'b0001, 1);
    step(4'b0001, 1);
    drain();
    set_d(1, -4096);
    step(4'b0010, 1);
    step(4'b0000, 1);
    do_reset();
    step(4'b1111, 1);
    drain();
    set_d(2, -1);
    step(4'b0100, 1);
    drain();
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NREQ; r++) set_d(r, int'($urandom_range(0, 8191)));
      step(4'($urandom), $urandom_range(0, 3) != 0);
    end
    drain();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
